// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC feeding InstROM and registers the fetched word for the decoder.
// Define FETCH_REL_BRANCH_EN to make BranchTarget a signed offset from InstRegAddr instead of an absolute address.
module inst_fetch #(
    parameter logic [6:0] START_PC = 7'd0
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic       Stall,
    input  logic       BranchTaken,
    input  logic [6:0] BranchTarget,
    input  logic       HaltReq,
    input  logic [8:0] InstOut,
    output logic [6:0] InstAddress,
    output logic [8:0] InstReg,
    output logic [6:0] InstRegAddr,
    output logic       InstValid,
    output logic       Done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetchState_t;

    fetchState_t state_r;
    logic [6:0]  pc_r;
    logic [8:0]  instReg_r;
    logic [6:0]  instRegAddr_r;
    logic        instValid_r;
    logic        done_r;
    logic [6:0]  branchDest_s;
    logic        haltNow_s;
    logic        branchNow_s;

    // Modulo-128 add of a 7-bit two's-complement offset equals sign-extend-then-truncate.
`ifdef FETCH_REL_BRANCH_EN
    assign branchDest_s = instRegAddr_r + BranchTarget;
`else
    assign branchDest_s = BranchTarget;
`endif

    // Decoder requests only count while IR holds a live instruction.
    assign haltNow_s   = HaltReq & instValid_r;
    assign branchNow_s = BranchTaken & instValid_r;

    // Fetch sequencer: state, PC, instruction register and status flags.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r       <= IDLE;
            pc_r          <= START_PC;
            instReg_r     <= 9'h000;
            instRegAddr_r <= 7'd0;
            instValid_r   <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    pc_r        <= START_PC;
                    instValid_r <= 1'b0;
                    done_r      <= 1'b0;
                    if (Start) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (haltNow_s) begin
                        state_r     <= HALTED;
                        instValid_r <= 1'b0;
                        done_r      <= 1'b1;
                    end else if (branchNow_s) begin
                        // Dropping InstValid discards the sequential word fetched this cycle.
                        pc_r        <= branchDest_s;
                        instValid_r <= 1'b0;
                    end else if (!Stall) begin
                        instReg_r     <= InstOut;
                        instRegAddr_r <= pc_r;
                        instValid_r   <= 1'b1;
                        pc_r          <= pc_r + 7'd1;
                    end else begin
                        state_r <= RUN;
                    end
                end
                HALTED: begin
                    if (Start) begin
                        state_r <= RUN;
                        pc_r    <= START_PC;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= HALTED;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    pc_r        <= START_PC;
                    instValid_r <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign InstAddress = pc_r;
    assign InstReg     = instReg_r;
    assign InstRegAddr = instRegAddr_r;
    assign InstValid   = instValid_r;
    assign Done        = done_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus random decoder traffic against a behavioural model.
// Honours FETCH_REL_BRANCH_EN so the same bench covers both branch-target builds.
module tb_inst_fetch;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Start = 1'b0;
    logic       Stall = 1'b0;
    logic       BranchTaken = 1'b0;
    logic [6:0] BranchTarget = 7'd0;
    logic       HaltReq = 1'b0;
    logic [8:0] InstOut;
    logic [6:0] InstAddress;
    logic [8:0] InstReg;
    logic [6:0] InstRegAddr;
    logic       InstValid;
    logic       Done;

    logic [8:0] rom [128];
    int nTests = 0;
    int nFail  = 0;

    // Behavioural model: mode 0 = waiting for Start, 1 = executing, 2 = halted.
    int         mMode;
    int         mPc;
    int         mIrAddr;
    logic [8:0] mIr;
    bit         mValid;
    bit         mDone;

    inst_fetch #(.START_PC(7'd0)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .HaltReq(HaltReq),
        .InstOut(InstOut), .InstAddress(InstAddress), .InstReg(InstReg),
        .InstRegAddr(InstRegAddr), .InstValid(InstValid), .Done(Done)
    );

    always #5 Clk = ~Clk;
    assign InstOut = rom[InstAddress];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mMode = 0; mPc = 0; mIrAddr = 0; mIr = 9'h000; mValid = 1'b0; mDone = 1'b0;
    endtask

    function automatic int branchDest(input logic [6:0] tgt);
        int off;
`ifdef FETCH_REL_BRANCH_EN
        off = (int'(tgt) >= 64) ? int'(tgt) - 128 : int'(tgt);
        return (mIrAddr + off + 128) % 128;
`else
        off = 0;
        return int'(tgt) + off;
`endif
    endfunction

    // Encodes a wanted destination as the BranchTarget value for the current build.
    function automatic logic [6:0] aimAt(input int dest);
        logic [6:0] v;
`ifdef FETCH_REL_BRANCH_EN
        v = 7'((dest - mIrAddr + 128) % 128);
`else
        v = 7'(dest);
`endif
        return v;
    endfunction

    task automatic modelStep();
        if (mMode == 0) begin
            mPc = 0;
            if (Start) mMode = 1;
        end else if (mMode == 1) begin
            if (HaltReq && mValid) begin
                mMode = 2; mValid = 1'b0; mDone = 1'b1;
            end else if (BranchTaken && mValid) begin
                mPc = branchDest(BranchTarget); mValid = 1'b0;
            end else if (!Stall) begin
                mIr = rom[mPc]; mIrAddr = mPc; mValid = 1'b1; mPc = (mPc + 1) % 128;
            end
        end else begin
            if (Start) begin
                mPc = 0; mDone = 1'b0; mMode = 1;
            end
        end
    endtask

    task automatic compareAll();
        checkVal("InstAddress", 32'(InstAddress), 32'(mPc));
        checkVal("InstReg", 32'(InstReg), 32'(mIr));
        checkVal("InstRegAddr", 32'(InstRegAddr), 32'(mIrAddr));
        checkVal("InstValid", 32'(InstValid), 32'(mValid));
        checkVal("Done", 32'(Done), 32'(mDone));
    endtask

    task automatic tick(input bit st, input bit sl, input bit bt, input bit hr, input logic [6:0] tg);
        Start = st; Stall = sl; BranchTaken = bt; HaltReq = hr; BranchTarget = tg;
        @(posedge Clk);
        modelStep();
        #1;
        compareAll();
    endtask

    // Runs plain fetches until the model's IR holds a live word from addr; expiry counts as a failure.
    task automatic runUntilIr(input int addr);
        int n;
        n = 0;
        while (!(mValid && mIrAddr == addr) && n < 300) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
            n++;
        end
        checkVal("reachIr", 32'(mValid && mIrAddr == addr), 32'd1);
    endtask

    task automatic resetPulse(input string tag);
        #3 Reset_n = 1'b0;
        #1;
        modelReset();
        checkVal({tag, "Addr"}, 32'(InstAddress), 32'd0);
        checkVal({tag, "Ir"}, 32'(InstReg), 32'h000);
        checkVal({tag, "IrAddr"}, 32'(InstRegAddr), 32'd0);
        checkVal({tag, "Valid"}, 32'(InstValid), 32'd0);
        checkVal({tag, "Done"}, 32'(Done), 32'd0);
        #4 Reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 9'($urandom);
        rom[0]  = 9'b100000000;
        rom[4]  = 9'b010011000;
        rom[15] = 9'b100000000;
        modelReset();

        #12;
        resetPulse("rst");
        tick(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        checkVal("idleHold", 32'(InstValid), 32'd0);

        // Start for one cycle, then free-running fetch.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
        checkVal("startNoValid", 32'(InstValid), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        checkVal("firstValid", 32'(InstValid), 32'd1);
        checkVal("firstIr", 32'(InstReg), 32'h100);
        checkVal("firstAddr", 32'(InstAddress), 32'd1);
        runUntilIr(4);
        checkVal("ir4", 32'(InstReg), 32'h098);

        // Stall for three cycles at InstRegAddr=5.
        runUntilIr(5);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
            checkVal("stallPc", 32'(InstAddress), 32'd6);
            checkVal("stallIrAddr", 32'(InstRegAddr), 32'd5);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        checkVal("resumeAt6", 32'(InstRegAddr), 32'd6);

        // Branch to 15 with a bubble, asserted together with Stall.
        tick(1'b0, 1'b1, 1'b1, 1'b0, aimAt(15));
        checkVal("brBubble", 32'(InstValid), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        checkVal("brIrAddr", 32'(InstRegAddr), 32'd15);
        checkVal("brIr", 32'(InstReg), 32'h100);

        // PC wrap through 127.
        tick(1'b0, 1'b0, 1'b1, 1'b0, aimAt(126));
        checkVal("wrap126", 32'(InstAddress), 32'd126);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        checkVal("wrap127", 32'(InstAddress), 32'd127);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        checkVal("wrap0", 32'(InstAddress), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        checkVal("wrap1", 32'(InstAddress), 32'd1);

        // Halt and branch together: halt wins.
        runUntilIr(9);
        tick(1'b0, 1'b0, 1'b1, 1'b1, aimAt(40));
        checkVal("haltDone", 32'(Done), 32'd1);
        checkVal("haltValid", 32'(InstValid), 32'd0);
        checkVal("haltPc", 32'(InstAddress), 32'd10);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 7'd3);
        checkVal("haltFrozen", 32'(InstAddress), 32'd10);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
        checkVal("restartPc", 32'(InstAddress), 32'd0);
        checkVal("restartDone", 32'(Done), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        checkVal("restartFetch", 32'(InstValid), 32'd1);

        // Asynchronous reset mid-run at PC=20, then the block must wait for Start.
        runUntilIr(19);
        checkVal("pc20", 32'(InstAddress), 32'd20);
        resetPulse("midRst");
        tick(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        checkVal("waitStart", 32'(InstAddress), 32'd0);

        // Random decoder traffic.
        for (int c = 0; c < 600; c++) begin
            tick(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0),
                 7'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
